// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code parser: turns E0/F0-prefixed byte streams into make/break events,
// tracks the held key and press count, and queues events in a FIFO. Optional macro: KEY_TYPEMATIC_FILTER_EN.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_code,
  output logic             out_ext,
  output logic             out_brk,
  output logic             key_down,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic [CNT_W-1:0] press_cnt,
  output logic             overflow,
  output logic             proto_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_run;
  logic             w_in;
  logic             w_is_e0;
  logic             w_is_f0;
  logic             w_emit;
  logic             w_ext;
  logic             w_brk;
  logic             w_perr;
  logic             w_match;
  logic             w_repeat;
  logic             w_new_make;
  logic             w_release;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic             w_wr_en;
  logic [9:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_key_down;
  logic [7:0]       r_held_code;
  logic             r_held_ext;
  logic [CNT_W-1:0] r_press_cnt;
  logic             r_overflow;
  logic             r_proto_err;

  // Input acceptance is held off until the edge after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_run <= 1'b0;
    else         r_run <= 1'b1;
  end

  assign w_in    = in_valid & r_run;
  assign w_is_e0 = (in_data == 8'hE0);
  assign w_is_f0 = (in_data == 8'hF0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_ext       = 1'b0;
    w_brk       = 1'b0;
    w_perr      = 1'b0;
    if (w_in) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_e0)      w_state_nxt = S_EXT;
          else if (w_is_f0) w_state_nxt = S_BRK;
          else              w_emit = 1'b1;
        end
        S_EXT: begin
          if (w_is_f0)      w_state_nxt = S_EXT_BRK;
          else if (w_is_e0) w_perr = 1'b1;
          else begin
            w_emit      = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          if (w_is_e0 || w_is_f0) w_perr = 1'b1;
          else begin
            w_emit      = 1'b1;
            w_brk       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (w_is_e0 || w_is_f0) w_perr = 1'b1;
          else begin
            w_emit      = 1'b1;
            w_ext       = 1'b1;
            w_brk       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_match    = r_key_down && (in_data == r_held_code) && (w_ext == r_held_ext);
  assign w_repeat   = w_emit && !w_brk && w_match;
  assign w_new_make = w_emit && !w_brk && !w_match;
  assign w_release  = w_emit && w_brk && w_match;

`ifdef KEY_TYPEMATIC_FILTER_EN
  assign w_push = w_emit && !w_repeat;
`else
  assign w_push = w_emit;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_key_down  <= 1'b0;
      r_held_code <= 8'h00;
      r_held_ext  <= 1'b0;
      r_press_cnt <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= w_perr;
      if (w_new_make) begin
        r_key_down  <= 1'b1;
        r_held_code <= in_data;
        r_held_ext  <= w_ext;
        r_press_cnt <= r_press_cnt + CNT_W'(1);
      end else if (w_release) begin
        r_key_down <= 1'b0;
      end
    end
  end

  // Extra pointer bit distinguishes full from empty.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && out_ready;
  assign w_wr_en = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr[AW-1:0]] <= {w_ext, w_brk, in_data};
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_wr_en) r_overflow <= 1'b1;
    end
  end

  assign out_valid                    = !w_empty;
  assign {out_ext, out_brk, out_code} = r_mem[r_rd_ptr[AW-1:0]];
  assign key_down                     = r_key_down;
  assign held_code                    = r_held_code;
  assign held_ext                     = r_held_ext;
  assign press_cnt                    = r_press_cnt;
  assign overflow                     = r_overflow;
  assign proto_err                    = r_proto_err;

endmodule
